rv_multicycle_ctrl: RTL and testbench
=====================================

Name: rv_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I datapath: sequences fetch, decode, execute, memory and writeback.
- Drives the immediate-generator format select, ALU operand muxes, PC/IR/register-file write enables and the memory request handshake.
- Sits between the instruction register / branch comparator and the shared instruction/data memory port.
- Also maintains a retired-instruction counter and a fault trap.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- MEM_TIMEOUT, 16: maximum cycles mem_req may wait for mem_ready before trapping; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- inst_opcode  in  7  IR[6:0]; valid from DECODE onward.
- branch_taken  in  1  branch comparator result; sampled in EXECUTE.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request strobe.
- mem_we  out  1  store (1) or read (0); valid only with mem_req.
- mem_addr_sel  out  1  address source: 0 = PC, 1 = ALU result.
- ir_we  out  1  instruction register load.
- pc_we  out  1  PC load.
- pc_sel  out  2  next PC: 0 = PC+4, 1 = PC+imm, 2 = {ALU[31:1],1'b0}.
- rf_we  out  1  register-file write.
- wb_sel  out  2  writeback source: 0 = ALU, 1 = load data, 2 = PC+4.
- alu_a_sel  out  1  ALU A operand: 0 = rs1, 1 = PC.
- alu_b_sel  out  1  ALU B operand: 0 = rs2, 1 = imm.
- imm_type  out  3  to imm_gen: 0 = I, 1 = S, 2 = B, 3 = U, 4 = J, 7 = none.
- state_o  out  3  current state, for debug.
- retired  out  1  one-cycle pulse when an instruction completes.
- instret  out  CNT_W  retired-instruction count.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  1 = illegal opcode, 2 = memory timeout.

Behaviour:
- States:
  - FETCH = 0, DECODE = 1, EXECUTE = 2, MEM = 3, WB = 4, TRAP = 5.
  - Codes 6 and 7 are unreachable; if entered, go to TRAP with cause 1.
- Reset (reset_n low at a clk edge):
  - state <= FETCH; instret, trap, trap_cause, timeout counter and latched class <= 0.
  - While reset_n is low, all strobes (mem_req, ir_we, pc_we, rf_we, retired) are forced to 0 combinationally.
  - Reset mid-operation abandons the instruction; no PC or register write occurs.
- FETCH:
  - mem_req = 1, mem_we = 0, mem_addr_sel = 0.
  - On mem_ready: ir_we = 1, then DECODE. Otherwise stay in FETCH.
- DECODE:
  - Classify inst_opcode:
    - LUI 0110111
    - AUIPC 0010111
    - JAL 1101111
    - JALR 1100111
    - BRANCH 1100011
    - LOAD 0000011
    - STORE 0100011
    - OP-IMM 0010011
    - OP 0110011
  - Latch the class into an internal register; later states use only the latched class.
  - Drive imm_type from the class: I for LOAD, OP-IMM, JALR; S for STORE; B for BRANCH; U for LUI, AUIPC; J for JAL; none for OP.
  - Legal opcode: go to EXECUTE. Any other opcode: go to TRAP with cause 1.
- EXECUTE:
  - imm_type is held from the latched class.
  - alu_a_sel = 1 for AUIPC. alu_b_sel = 1 for every class except OP and BRANCH.
  - BRANCH: pc_we = 1, pc_sel = branch_taken ? 1 : 0, retired = 1, then FETCH.
  - LOAD or STORE: go to MEM. All others: go to WB.
- MEM:
  - mem_req = 1, mem_addr_sel = 1, mem_we = 1 for STORE.
  - On mem_ready:
    - STORE: pc_we = 1, pc_sel = 0, retired = 1, then FETCH.
    - LOAD: go to WB.
- WB:
  - rf_we = 1, pc_we = 1, retired = 1, then FETCH.
  - wb_sel: LOAD 1; JAL and JALR 2; otherwise 0.
  - pc_sel: JAL 1; JALR 2; otherwise 0.
  - For LUI, the ALU result is imm (A operand zeroed by the datapath).
- Latency with mem_ready high immediately:
  - BRANCH 3 cycles; STORE 4; OP, OP-IMM, LUI, AUIPC, JAL, JALR 4; LOAD 5.
- Timeout (MEM_TIMEOUT > 0):
  - A counter increments each cycle mem_req is high without mem_ready and clears on mem_ready or on a state change.
  - When the counter equals MEM_TIMEOUT and mem_ready is still low: go to TRAP with cause 2.
  - mem_ready arriving on that same cycle wins; no trap.
- TRAP:
  - All strobes are 0 and trap = 1.
  - Only reset exits TRAP. The first fault's cause is preserved.
- instret:
  - Increments on the clk edge where retired = 1.
  - Wraps from all-ones to 0 silently.
- Outputs not listed for a state are 0 in that state.

Test Plan:
- ADDI x1,x0,1 (0x00100093), mem_ready always 1 -> states 0,1,2,4,0; imm_type = 0; rf_we and pc_we high in cycle 4 with pc_sel = 0; instret = 1.
- LW with mem_ready delayed 3 cycles in MEM -> MEM held for 4 cycles with mem_req = 1, mem_addr_sel = 1; WB with wb_sel = 1; 8 cycles total.
- SW (0x0011A1A3) -> imm_type = 1 in DECODE/EXECUTE; mem_we = 1 in MEM; pc_we in MEM and no rf_we; retired after 4 cycles.
- BEQ: branch_taken = 1 -> pc_sel = 1 in EXECUTE; branch_taken = 0 -> pc_sel = 0; both take 3 cycles and rf_we is never asserted.
- Opcode 0x7F -> TRAP with trap_cause = 1 and instret unchanged; stays in TRAP 20 cycles; reset_n low for one edge -> FETCH, trap = 0.
- MEM_TIMEOUT = 4, mem_ready held low in FETCH -> TRAP with cause 2 after 4 waiting cycles; separately, reset_n low mid-MEM -> FETCH next cycle with no pc_we or rf_we.

Source files
------------

// File: rtl/rv_multicycle_ctrl_if.sv
// Memory request handshake between the multi-cycle controller and the shared
// instruction/data memory port.
interface rv_multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/mem/writeback sequencing,
// retired-instruction counter and sticky fault trap.
module rv_multicycle_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    rv_multicycle_ctrl_if.master   mem,
    input  logic [6:0]             inst_opcode,
    input  logic                   branch_taken,
    output logic                   ir_we,
    output logic                   pc_we,
    output logic [1:0]             pc_sel,
    output logic                   rf_we,
    output logic [1:0]             wb_sel,
    output logic                   alu_a_sel,
    output logic                   alu_b_sel,
    output logic [2:0]             imm_type,
    output logic [2:0]             state_o,
    output logic                   retired,
    output logic [CNT_W-1:0]       instret,
    output logic                   trap,
    output logic [1:0]             trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_NONE   = 4'd0,
        C_LUI    = 4'd1,
        C_AUIPC  = 4'd2,
        C_JAL    = 4'd3,
        C_JALR   = 4'd4,
        C_BRANCH = 4'd5,
        C_LOAD   = 4'd6,
        C_STORE  = 4'd7,
        C_OPIMM  = 4'd8,
        C_OP     = 4'd9
    } class_t;

    localparam int TO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    function automatic class_t decode_class(input logic [6:0] op);
        case (op)
            7'b0110111: decode_class = C_LUI;
            7'b0010111: decode_class = C_AUIPC;
            7'b1101111: decode_class = C_JAL;
            7'b1100111: decode_class = C_JALR;
            7'b1100011: decode_class = C_BRANCH;
            7'b0000011: decode_class = C_LOAD;
            7'b0100011: decode_class = C_STORE;
            7'b0010011: decode_class = C_OPIMM;
            7'b0110011: decode_class = C_OP;
            default:    decode_class = C_NONE;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input class_t c);
        case (c)
            C_LOAD, C_OPIMM, C_JALR: imm_of = 3'd0;
            C_STORE:                 imm_of = 3'd1;
            C_BRANCH:                imm_of = 3'd2;
            C_LUI, C_AUIPC:          imm_of = 3'd3;
            C_JAL:                   imm_of = 3'd4;
            default:                 imm_of = 3'd7;
        endcase
    endfunction

    state_t            r_state;
    class_t            r_class;
    logic [TO_W-1:0]   r_to_cnt;
    logic [CNT_W-1:0]  r_instret;
    logic [1:0]        r_trap_cause;

    state_t            w_next_state;
    class_t            w_dec_class;
    logic              w_to_hit;
    logic              w_mem_req;
    logic              w_mem_we;
    logic              w_mem_addr_sel;
    logic              w_ir_we;
    logic              w_pc_we;
    logic [1:0]        w_pc_sel;
    logic              w_rf_we;
    logic [1:0]        w_wb_sel;
    logic              w_alu_a_sel;
    logic              w_alu_b_sel;
    logic [2:0]        w_imm_type;
    logic              w_retired;
    logic [1:0]        w_cause;

    assign w_dec_class = decode_class(inst_opcode);
    assign w_to_hit    = (MEM_TIMEOUT > 0) && (r_to_cnt == TO_LIMIT);

    // Next-state and Mealy output decode
    always_comb begin
        w_next_state   = r_state;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr_sel = 1'b0;
        w_ir_we        = 1'b0;
        w_pc_we        = 1'b0;
        w_pc_sel       = 2'd0;
        w_rf_we        = 1'b0;
        w_wb_sel       = 2'd0;
        w_alu_a_sel    = 1'b0;
        w_alu_b_sel    = 1'b0;
        w_imm_type     = 3'd0;
        w_retired      = 1'b0;
        w_cause        = 2'd0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (mem.mem_ready) begin
                    w_ir_we      = 1'b1;
                    w_next_state = S_DECODE;
                end else if (w_to_hit) begin
                    w_next_state = S_TRAP;
                    w_cause      = 2'd2;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            S_DECODE: begin
                w_imm_type = imm_of(w_dec_class);
                if (w_dec_class != C_NONE) begin
                    w_next_state = S_EXECUTE;
                end else begin
                    w_next_state = S_TRAP;
                    w_cause      = 2'd1;
                end
            end
            S_EXECUTE: begin
                w_imm_type  = imm_of(r_class);
                w_alu_a_sel = (r_class == C_AUIPC);
                w_alu_b_sel = !((r_class == C_OP) || (r_class == C_BRANCH));
                if (r_class == C_BRANCH) begin
                    w_pc_we      = 1'b1;
                    w_pc_sel     = branch_taken ? 2'd1 : 2'd0;
                    w_retired    = 1'b1;
                    w_next_state = S_FETCH;
                end else if ((r_class == C_LOAD) || (r_class == C_STORE)) begin
                    w_next_state = S_MEM;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_MEM: begin
                w_mem_req      = 1'b1;
                w_mem_addr_sel = 1'b1;
                w_mem_we       = (r_class == C_STORE);
                if (mem.mem_ready) begin
                    if (r_class == C_STORE) begin
                        w_pc_we      = 1'b1;
                        w_retired    = 1'b1;
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state = S_WB;
                    end
                end else if (w_to_hit) begin
                    w_next_state = S_TRAP;
                    w_cause      = 2'd2;
                end else begin
                    w_next_state = S_MEM;
                end
            end
            S_WB: begin
                w_rf_we      = 1'b1;
                w_pc_we      = 1'b1;
                w_retired    = 1'b1;
                w_next_state = S_FETCH;
                case (r_class)
                    C_LOAD: begin
                        w_wb_sel = 2'd1;
                        w_pc_sel = 2'd0;
                    end
                    C_JAL: begin
                        w_wb_sel = 2'd2;
                        w_pc_sel = 2'd1;
                    end
                    C_JALR: begin
                        w_wb_sel = 2'd2;
                        w_pc_sel = 2'd2;
                    end
                    default: begin
                        w_wb_sel = 2'd0;
                        w_pc_sel = 2'd0;
                    end
                endcase
            end
            S_TRAP: begin
                w_next_state = S_TRAP;
            end
            default: begin
                w_next_state = S_TRAP;
                w_cause      = 2'd1;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Instruction class latched in DECODE so later states ignore IR changes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_class <= C_NONE;
        end else if (r_state == S_DECODE) begin
            r_class <= w_dec_class;
        end else begin
            r_class <= r_class;
        end
    end

    // Memory wait counter: runs only while a request is stalled in one state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else if ((MEM_TIMEOUT == 0) || (w_next_state != r_state) ||
                     mem.mem_ready || !w_mem_req) begin
            r_to_cnt <= {TO_W{1'b0}};
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    // Trap cause captured only on entry so the first fault is kept
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_trap_cause <= 2'd0;
        end else if ((r_state != S_TRAP) && (w_next_state == S_TRAP)) begin
            r_trap_cause <= w_cause;
        end else begin
            r_trap_cause <= r_trap_cause;
        end
    end

    // Retired-instruction counter, wraps silently
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_instret <= {CNT_W{1'b0}};
        end else if (retired) begin
            r_instret <= r_instret + CNT_W'(1);
        end else begin
            r_instret <= r_instret;
        end
    end

    assign mem.mem_req      = w_mem_req & reset_n;
    assign mem.mem_we       = w_mem_we;
    assign mem.mem_addr_sel = w_mem_addr_sel;
    assign ir_we            = w_ir_we & reset_n;
    assign pc_we            = w_pc_we & reset_n;
    assign rf_we            = w_rf_we & reset_n;
    assign retired          = w_retired & reset_n;
    assign pc_sel           = w_pc_sel;
    assign wb_sel           = w_wb_sel;
    assign alu_a_sel        = w_alu_a_sel;
    assign alu_b_sel        = w_alu_b_sel;
    assign imm_type         = w_imm_type;
    assign state_o          = r_state;
    assign instret          = r_instret;
    assign trap             = (r_state == S_TRAP);
    assign trap_cause       = r_trap_cause;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: instruction classes, memory stalls,
// timeout boundary, illegal-opcode trap and reset behaviour.
module tb_rv_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  inst_opcode;
    logic        branch_taken;
    logic        ir_we, pc_we, rf_we, alu_a_sel, alu_b_sel, retired, trap;
    logic [1:0]  pc_sel, wb_sel, trap_cause;
    logic [2:0]  imm_type, state_o;
    logic [31:0] instret;

    int n_tests = 0;
    int n_fail  = 0;

    rv_multicycle_ctrl_if mem_bus ();

    rv_multicycle_ctrl #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem          (mem_bus),
        .inst_opcode  (inst_opcode),
        .branch_taken (branch_taken),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .imm_type     (imm_type),
        .state_o      (state_o),
        .retired      (retired),
        .instret      (instret),
        .trap         (trap),
        .trap_cause   (trap_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input string tag, input logic [2:0] st, input logic mreq,
                           input logic irwe, input logic pcwe, input logic rfwe,
                           input logic ret);
        chk({tag, ".state"},   {29'd0, state_o},          {29'd0, st});
        chk({tag, ".mem_req"}, {31'd0, mem_bus.mem_req},  {31'd0, mreq});
        chk({tag, ".ir_we"},   {31'd0, ir_we},            {31'd0, irwe});
        chk({tag, ".pc_we"},   {31'd0, pc_we},            {31'd0, pcwe});
        chk({tag, ".rf_we"},   {31'd0, rf_we},            {31'd0, rfwe});
        chk({tag, ".retired"}, {31'd0, retired},          {31'd0, ret});
    endtask

    // Four-cycle register-writing instruction with memory ready at once
    task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] ei,
                           input logic ea, input logic eb, input logic [1:0] ewb,
                           input logic [1:0] epc, input logic [31:0] ecnt);
        inst_opcode = op;
        mem_bus.mem_ready = 1'b1;
        #1;
        strobes({tag, ".F"}, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk({tag, ".F.addr_sel"}, {31'd0, mem_bus.mem_addr_sel}, 32'd0);
        tick();
        strobes({tag, ".D"}, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, ".D.imm"}, {29'd0, imm_type}, {29'd0, ei});
        tick();
        strobes({tag, ".E"}, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, ".E.imm"},   {29'd0, imm_type},  {29'd0, ei});
        chk({tag, ".E.alu_a"}, {31'd0, alu_a_sel}, {31'd0, ea});
        chk({tag, ".E.alu_b"}, {31'd0, alu_b_sel}, {31'd0, eb});
        tick();
        strobes({tag, ".W"}, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk({tag, ".W.wb_sel"}, {30'd0, wb_sel}, {30'd0, ewb});
        chk({tag, ".W.pc_sel"}, {30'd0, pc_sel}, {30'd0, epc});
        tick();
        chk({tag, ".done.state"}, {29'd0, state_o}, 32'd0);
        chk({tag, ".instret"}, instret, ecnt);
    endtask

    task automatic run_branch(input string tag, input logic taken, input logic [1:0] epc,
                              input logic [31:0] ecnt);
        inst_opcode = 7'h63;
        branch_taken = taken;
        mem_bus.mem_ready = 1'b1;
        #1;
        strobes({tag, ".F"}, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk({tag, ".D.imm"}, {29'd0, imm_type}, 32'd2);
        tick();
        strobes({tag, ".E"}, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk({tag, ".E.pc_sel"}, {30'd0, pc_sel},    {30'd0, epc});
        chk({tag, ".E.alu_b"},  {31'd0, alu_b_sel}, 32'd0);
        tick();
        chk({tag, ".done.state"}, {29'd0, state_o}, 32'd0);
        chk({tag, ".instret"}, instret, ecnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        inst_opcode = 7'h00;
        branch_taken = 1'b0;
        mem_bus.mem_ready = 1'b1;
        tick();
        tick();
        strobes("rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.instret", instret, 32'd0);
        chk("rst.trap", {31'd0, trap}, 32'd0);
        chk("rst.cause", {30'd0, trap_cause}, 32'd0);
        reset_n = 1'b1;

        run_alu("addi",  7'h13, 3'd0, 1'b0, 1'b1, 2'd0, 2'd0, 32'd1);

        // LW with three stalled MEM cycles: eight cycles total
        inst_opcode = 7'h03;
        mem_bus.mem_ready = 1'b1;
        #1;
        strobes("lw.F", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("lw.D.imm", {29'd0, imm_type}, 32'd0);
        tick();
        chk("lw.E.state", {29'd0, state_o}, 32'd2);
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_bus.mem_ready = 1'b0;
            #1;
            strobes("lw.Mwait", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("lw.Mwait.addr_sel", {31'd0, mem_bus.mem_addr_sel}, 32'd1);
            chk("lw.Mwait.mem_we",   {31'd0, mem_bus.mem_we},       32'd0);
            tick();
        end
        mem_bus.mem_ready = 1'b1;
        #1;
        strobes("lw.Mdone", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        strobes("lw.W", 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("lw.W.wb_sel", {30'd0, wb_sel}, 32'd1);
        tick();
        chk("lw.done.state", {29'd0, state_o}, 32'd0);
        chk("lw.instret", instret, 32'd2);

        // SW retires from MEM with no register write
        inst_opcode = 7'h23;
        #1;
        tick();
        chk("sw.D.imm", {29'd0, imm_type}, 32'd1);
        tick();
        chk("sw.E.imm", {29'd0, imm_type}, 32'd1);
        chk("sw.E.alu_b", {31'd0, alu_b_sel}, 32'd1);
        tick();
        strobes("sw.M", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("sw.M.mem_we", {31'd0, mem_bus.mem_we}, 32'd1);
        chk("sw.M.pc_sel", {30'd0, pc_sel}, 32'd0);
        tick();
        chk("sw.done.state", {29'd0, state_o}, 32'd0);
        chk("sw.instret", instret, 32'd3);

        run_branch("beq_t", 1'b1, 2'd1, 32'd4);
        run_branch("beq_n", 1'b0, 2'd0, 32'd5);
        run_alu("jal",   7'h6F, 3'd4, 1'b0, 1'b1, 2'd2, 2'd1, 32'd6);
        run_alu("jalr",  7'h67, 3'd0, 1'b0, 1'b1, 2'd2, 2'd2, 32'd7);
        run_alu("auipc", 7'h17, 3'd3, 1'b1, 1'b1, 2'd0, 2'd0, 32'd8);
        run_alu("lui",   7'h37, 3'd3, 1'b0, 1'b1, 2'd0, 2'd0, 32'd9);
        run_alu("op",    7'h33, 3'd7, 1'b0, 1'b0, 2'd0, 2'd0, 32'd10);

        // Ready arriving on the cycle the wait counter reaches the limit wins
        inst_opcode = 7'h13;
        for (int i = 0; i < 4; i++) begin
            mem_bus.mem_ready = 1'b0;
            #1;
            strobes("tob.wait", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        mem_bus.mem_ready = 1'b1;
        #1;
        strobes("tob.last", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("tob.D.state", {29'd0, state_o}, 32'd1);
        chk("tob.trap", {31'd0, trap}, 32'd0);
        tick();
        tick();
        tick();
        chk("tob.instret", instret, 32'd11);

        // Illegal opcode traps and holds until reset
        inst_opcode = 7'h7F;
        #1;
        tick();
        chk("ill.D.imm", {29'd0, imm_type}, 32'd7);
        tick();
        chk("ill.trap", {31'd0, trap}, 32'd1);
        chk("ill.cause", {30'd0, trap_cause}, 32'd1);
        chk("ill.instret", instret, 32'd11);
        for (int i = 0; i < 20; i++) begin
            mem_bus.mem_ready = (i % 2 == 0) ? 1'b1 : 1'b0;
            #1;
            strobes("ill.hold", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("ill.cause_kept", {30'd0, trap_cause}, 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        chk("ill.rst.state", {29'd0, state_o}, 32'd0);
        chk("ill.rst.trap", {31'd0, trap}, 32'd0);
        chk("ill.rst.cause", {30'd0, trap_cause}, 32'd0);
        chk("ill.rst.instret", instret, 32'd0);

        // Fetch stalled past the limit traps with cause 2
        for (int i = 0; i < 4; i++) begin
            mem_bus.mem_ready = 1'b0;
            #1;
            chk("to.wait.state", {29'd0, state_o}, 32'd0);
            tick();
        end
        #1;
        chk("to.limit.state", {29'd0, state_o}, 32'd0);
        chk("to.limit.trap", {31'd0, trap}, 32'd0);
        tick();
        chk("to.trap", {31'd0, trap}, 32'd1);
        chk("to.state", {29'd0, state_o}, 32'd5);
        chk("to.cause", {30'd0, trap_cause}, 32'd2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;

        // Reset in the middle of a load abandons it
        inst_opcode = 7'h03;
        mem_bus.mem_ready = 1'b1;
        #1;
        chk("rmem.F.state", {29'd0, state_o}, 32'd0);
        tick();
        tick();
        mem_bus.mem_ready = 1'b0;
        tick();
        chk("rmem.M.state", {29'd0, state_o}, 32'd3);
        reset_n = 1'b0;
        mem_bus.mem_ready = 1'b1;
        #1;
        strobes("rmem.rst", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("rmem.after.state", {29'd0, state_o}, 32'd0);
        chk("rmem.after.pc_we", {31'd0, pc_we}, 32'd0);
        chk("rmem.after.rf_we", {31'd0, rf_we}, 32'd0);
        chk("rmem.after.instret", instret, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
